// File: rtl/mux4_1.sv
// Single-bit 4:1 multiplexer with a registered copy of the result.
// Leaf cell for wide datapath muxes: one instance per bit, with the four
// sources packed as {in3[i], in2[i], in1[i], in0[i]} onto in.
module mux4_1 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] in,
  input  logic [1:0] sel,
  output logic       out,
  output logic       out_q
);

  logic pair_lo;
  logic pair_hi;

  // Two-level tree: sel[0] picks within each pair, sel[1] picks the pair.
  // Ternaries let an X/Z select or a selected X/Z input reach out in simulation.
  always_comb begin
    pair_lo = sel[0] ? in[1] : in[0];
    pair_hi = sel[0] ? in[3] : in[2];
    out     = sel[1] ? pair_hi : pair_lo;
  end

  // Pipeline copy of out; asynchronous clear holds it at 0 for as long as reset_n is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out;
    end
  end

endmodule

// File: tb/tb_mux4_1.sv
// Randomized, scoreboard-checked bench for mux4_1: a single instance plus a
// 7-bit wide mux built from one instance per bit.
`timescale 1ns / 1ps
module tb_mux4_1;

  logic       clk;
  logic       reset_n;
  logic [3:0] in;
  logic [1:0] sel;
  logic       out;
  logic       out_q;

  // Wide-use stimulus and results.
  logic [6:0] in0, in1, in2, in3;
  logic [1:0] wsel;
  logic [6:0] wout;
  logic [6:0] wout_q;

  int checks = 0;
  int errors = 0;

  // Which DUT output an expectation refers to.
  localparam logic [1:0] KOut   = 2'd0;
  localparam logic [1:0] KOutQ  = 2'd1;
  localparam logic [1:0] KWide  = 2'd2;
  localparam logic [1:0] KWideQ = 2'd3;

  typedef struct {
    logic [1:0] which;
    logic [6:0] exp;
    int         id;
  } sb_item_t;

  sb_item_t sb_q[$];
  event     chk_ev;
  int       next_id = 0;

  mux4_1 u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (in),
    .sel     (sel),
    .out     (out),
    .out_q   (out_q)
  );

  for (genvar b = 0; b < 7; b++) begin : g_wide
    mux4_1 u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .in      ({in3[b], in2[b], in1[b], in0[b]}),
      .sel     (wsel),
      .out     (wout[b]),
      .out_q   (wout_q[b])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the selected bit is simply bit number sel of in.
  function automatic logic [6:0] ref_bit(input logic [3:0] v, input logic [1:0] s);
    return {6'd0, ((v >> s) & 4'd1) != 4'd0};
  endfunction

  // Push an expectation and wake the monitor; the short delay lets it sample
  // before the stimulus moves on.
  task automatic expect_val(input logic [1:0] which, input logic [6:0] exp);
    sb_item_t it;
    it.which = which;
    it.exp   = exp;
    it.id    = next_id;
    next_id++;
    sb_q.push_back(it);
    ->chk_ev;
    #0.01;
  endtask

  // Monitor: pops every queued expectation and compares with the live output.
  initial begin
    sb_item_t   it;
    logic [6:0] act;
    string      nm;
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        case (it.which)
          KOut:    begin act = {6'd0, out};   nm = "out";    end
          KOutQ:   begin act = {6'd0, out_q}; nm = "out_q";  end
          KWide:   begin act = wout;          nm = "wide";   end
          default: begin act = wout_q;        nm = "wide_q"; end
        endcase
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s #%0d at %0t: got %b expected %b", nm, it.id, $time, act, it.exp);
        end
      end
    end
  end

  // Watchdog: the bench must never hang.
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    logic [3:0] mask;
    logic [6:0] prev;
    logic [6:0] vecs [4];

    reset_n = 1'b0;
    in      = 4'b1111;
    sel     = 2'd3;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    wsel    = 2'd0;

    // Reset held with clock running: out_q pinned at 0, out still live.
    repeat (3) begin
      @(posedge clk); #1;
      expect_val(KOutQ, 7'd0);
      expect_val(KOut, 7'd1);
    end

    // Release between edges; first rising edge loads the selected 1.
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    expect_val(KOutQ, 7'd1);

    // Async reset mid-cycle clears out_q with no clock edge.
    @(negedge clk); #1;
    reset_n = 1'b0;
    #0.5;
    expect_val(KOutQ, 7'd0);
    @(posedge clk); #1;
    expect_val(KOutQ, 7'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed pattern 0110 across all selects.
    in = 4'b0110;
    for (int s = 0; s < 4; s++) begin
      sel = s[1:0];
      #1;
      expect_val(KOut, ref_bit(4'b0110, s[1:0]));
      #9;
    end

    // Exhaustive: every in/sel, then flip all unselected bits.
    for (int v = 0; v < 16; v++) begin
      for (int s = 0; s < 4; s++) begin
        pat  = v[3:0];
        in   = pat;
        sel  = s[1:0];
        #1;
        expect_val(KOut, ref_bit(pat, s[1:0]));
        mask = 4'hf & ~(4'b0001 << s);
        in   = pat ^ mask;
        #1;
        expect_val(KOut, ref_bit(pat, s[1:0]));
        #8;
      end
    end

    // Pipeline latency: select change right after an edge.
    @(negedge clk);
    in  = 4'b1000;
    sel = 2'd0;
    @(posedge clk); #1;
    expect_val(KOutQ, 7'd0);
    sel = 2'd3;
    #0.15;
    expect_val(KOut, 7'd1);
    expect_val(KOutQ, 7'd0);
    @(posedge clk); #1;
    expect_val(KOutQ, 7'd1);

    // Randomized traffic with registered-copy tracking.
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      pat = 4'($urandom);
      in  = pat;
      sel = 2'($urandom_range(0, 3));
      #1;
      prev = ref_bit(pat, sel);
      expect_val(KOut, prev);
      @(posedge clk); #1;
      expect_val(KOutQ, prev);
    end

    // Wide use: 7 bit-slices select whole vectors.
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) vecs[k] = 7'($urandom);
      in0 = vecs[0]; in1 = vecs[1]; in2 = vecs[2]; in3 = vecs[3];
      for (int s = 0; s < 4; s++) begin
        @(negedge clk);
        wsel = s[1:0];
        #1;
        expect_val(KWide, vecs[s]);
        @(posedge clk); #1;
        expect_val(KWideQ, vecs[s]);
      end
    end

    #5;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
